// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour types and the fixed 16-entry sprite palette.
// Rev 1.0
`default_nettype none

package sprite_pkg;

  typedef logic [3:0] pal_idx_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  localparam rgb12_t SPRITE_PALETTE [0:15] = '{
    rgb12_t'(12'hFFF), rgb12_t'(12'h811), rgb12_t'(12'hF91), rgb12_t'(12'hCCB),
    rgb12_t'(12'h521), rgb12_t'(12'h353), rgb12_t'(12'hE41), rgb12_t'(12'hFD0),
    rgb12_t'(12'h998), rgb12_t'(12'hEDD), rgb12_t'(12'h953), rgb12_t'(12'hE97),
    rgb12_t'(12'h675), rgb12_t'(12'h232), rgb12_t'(12'hD73), rgb12_t'(12'h111)
  };

  function automatic rgb12_t palette_lookup(input pal_idx_t idx);
    return SPRITE_PALETTE[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_palette_arbiter_if.sv
// sprite_palette_arbiter_if: renderer-side request bus and colour result bus.
// Rev 1.0
`default_nettype none

interface sprite_palette_arbiter_if
  import sprite_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]           req;
  pal_idx_t [N_REQ-1:0]       index;
  logic [N_REQ-1:0]           grant;
  logic                       rgb_valid;
  logic [ID_W-1:0]            rgb_id;
  logic [3:0]                 red;
  logic [3:0]                 green;
  logic [3:0]                 blue;
  logic                       transparent;

  modport master (
    output req, index,
    input  grant, rgb_valid, rgb_id, red, green, blue, transparent
  );

  modport slave (
    input  req, index,
    output grant, rgb_valid, rgb_id, red, green, blue, transparent
  );

endinterface

`default_nettype wire

// File: rtl/sprite_palette_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr, one-hot plus encoded grant.
// Rev 1.0
`default_nettype none

module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                        = 1'b1;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        grant_id                     = ID_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_palette_arbiter.sv
// sprite_palette_arbiter: round-robin shared palette lookup, two-stage registered result.
// Rev 1.0
`default_nettype none

module sprite_palette_arbiter
  import sprite_pkg::*;
#(
  parameter int       N_REQ      = 4,
  parameter int       ID_W       = 2,
  parameter pal_idx_t TRANSP_IDX = 4'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  sprite_palette_arbiter_if.slave   bus
);

  logic [N_REQ-1:0] req_gated;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             any_grant;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_next;
  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  pal_idx_t         s1_idx;
  rgb12_t           s1_rgb;

  // Masking requests during reset keeps grant low without touching the picker.
  assign req_gated = bus.req & {N_REQ{~rst}};

  rr_picker #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_picker (
    .req      (req_gated),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.grant   = grant;
  assign any_grant   = |grant;
  assign rr_ptr_next = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign s1_rgb      = palette_lookup(s1_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      s1_valid        <= 1'b0;
      s1_id           <= '0;
      s1_idx          <= '0;
      bus.rgb_valid   <= 1'b0;
      bus.rgb_id      <= '0;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
      bus.transparent <= 1'b0;
    end else begin
      s1_valid      <= any_grant;
      bus.rgb_valid <= s1_valid;
      if (any_grant) begin
        rr_ptr <= rr_ptr_next;
        s1_id  <= grant_id;
        s1_idx <= bus.index[grant_id];
      end
      // Result fields hold between valid cycles so the compositor sees a stable bus.
      if (s1_valid) begin
        bus.rgb_id      <= s1_id;
        bus.red         <= s1_rgb.red;
        bus.green       <= s1_rgb.green;
        bus.blue        <= s1_rgb.blue;
        bus.transparent <= (s1_idx == TRANSP_IDX);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_palette_arbiter.sv
// tb_sprite_palette_arbiter: directed and random stimulus against a cycle-indexed reference model.
// Rev 1.0
`default_nettype none

module tb_sprite_palette_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_palette_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

  sprite_palette_arbiter #(
    .N_REQ      (N),
    .ID_W       (IW),
    .TRANSP_IDX (4'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [11:0] pal [16] = '{
    12'hFFF, 12'h811, 12'hF91, 12'hCCB, 12'h521, 12'h353, 12'hE41, 12'hFD0,
    12'h998, 12'hEDD, 12'h953, 12'hE97, 12'h675, 12'h232, 12'hD73, 12'h111
  };

  typedef struct {
    int due;
    int id;
    int idx;
  } exp_t;

  exp_t        q[$];
  int          mptr = 0;
  int          cyc = 0;
  logic [11:0] last_rgb = '0;
  int          last_id = 0;
  logic        last_tr = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational grant and registered result, advance model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0][3:0] ix, input logic rs,
                      output int g);
    logic [N-1:0] eg;
    exp_t e;
    @(negedge clk);
    rst       = rs;
    bus.req   = r;
    bus.index = ix;
    #1;
    g = -1;
    if (!rs) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && r[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("grant", 32'(bus.grant), 32'(eg));
    if (q.size() > 0 && q[0].due == cyc) begin
      e        = q.pop_front();
      last_rgb = pal[e.idx];
      last_id  = e.id;
      last_tr  = (e.idx == 0);
      check("rgb_valid", 32'(bus.rgb_valid), 32'd1);
    end else begin
      check("rgb_valid", 32'(bus.rgb_valid), 32'd0);
    end
    check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(last_rgb));
    check("rgb_id", 32'(bus.rgb_id), 32'(last_id));
    check("transparent", 32'(bus.transparent), 32'(last_tr));
    @(posedge clk);
    if (rs) begin
      q.delete();
      mptr     = 0;
      last_rgb = '0;
      last_id  = 0;
      last_tr  = 1'b0;
    end else if (g >= 0) begin
      q.push_back('{due: cyc + 2, id: g, idx: int'(ix[g])});
      mptr = (g + 1) % N;
    end
    cyc++;
  endtask

  initial begin
    logic [N-1:0][3:0] ix;
    logic [N-1:0]      r;
    int                g;

    bus.req   = '0;
    bus.index = '0;

    // Reset with every requester asking; then fairness and wrap from requester 0.
    ix = '0;
    ix[0] = 4'h1; ix[1] = 4'h2; ix[2] = 4'h3; ix[3] = 4'h4;
    step('1, ix, 1'b1, g);
    step('1, ix, 1'b1, g);
    check("grant_after_reset", 32'(g), 32'(-1));
    for (int i = 0; i < 5; i++) begin
      step('1, ix, 1'b0, g);
      check("rr_order", 32'(g), 32'(i % N));
    end
    step('0, ix, 1'b0, g);
    step('0, ix, 1'b0, g);
    check("rgb_wrap_color", 32'({bus.red, bus.green, bus.blue}), 32'h811);

    // Single requester 2 after a fresh reset.
    step('0, ix, 1'b1, g);
    ix = '0; ix[2] = 4'h7;
    step(4'b0100, ix, 1'b0, g);
    step('0, ix, 1'b0, g);
    step('0, ix, 1'b0, g);
    check("single_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFD0);

    // Transparency on entry 0, opaque on entry F.
    ix = '0; ix[0] = 4'h0;
    step(4'b0001, ix, 1'b0, g);
    ix[0] = 4'hF;
    step(4'b0001, ix, 1'b0, g);
    step('0, ix, 1'b0, g);
    check("transp_flag", 32'(bus.transparent), 32'd1);
    step('0, ix, 1'b0, g);
    check("opaque_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h111);

    // Pointer skip: after granting 0, only 0 and 3 request.
    step('0, ix, 1'b1, g);
    ix = '0; ix[0] = 4'h5; ix[3] = 4'h9;
    step(4'b0001, ix, 1'b0, g);
    step(4'b1001, ix, 1'b0, g);
    check("skip_to_3", 32'(g), 32'd3);
    step(4'b0001, ix, 1'b0, g);
    check("skip_back_0", 32'(g), 32'd0);
    step('0, ix, 1'b0, g);
    step('0, ix, 1'b0, g);

    // Reset lands on an in-flight lookup.
    ix = '0; ix[1] = 4'h6;
    step(4'b0010, ix, 1'b0, g);
    step('0, ix, 1'b1, g);
    step('0, ix, 1'b0, g);
    check("flight_discard", 32'(bus.rgb_valid), 32'd0);
    step('1, ix, 1'b0, g);
    check("ptr_cleared", 32'(g), 32'd0);

    // Random: held requests keep their index, occasional abandon and reset.
    r = '0;
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] rn;
      for (int i = 0; i < N; i++) begin
        if (r[i] && g != i && $urandom_range(7) != 0) begin
          rn[i] = 1'b1;
        end else begin
          rn[i] = ($urandom_range(2) != 0);
          ix[i] = 4'($urandom_range(15));
        end
      end
      r = rn;
      step(r, ix, ($urandom_range(39) == 0), g);
    end
    step('0, ix, 1'b0, g);
    step('0, ix, 1'b0, g);
    step('0, ix, 1'b0, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_palette_arbiter.md
# sprite_palette_arbiter

Shares one 16-entry, 12-bit sprite palette lookup among up to N_REQ sprite renderers (tanks, shells, HUD icons) that each produce 4-bit colour indices. Each cycle it grants at most one requester by round-robin, performs the lookup, and returns the registered RGB colour tagged with the requester ID and a transparency flag. It sits between the per-sprite renderers and the pixel compositor ahead of the VGA output.

## Interface
- N_REQ, default 4, number of requesters (2..8)
- ID_W, default 2, width of requester ID; must equal $clog2(N_REQ)
- TRANSP_IDX, default 4'h0, palette index reported as transparent (entry 0, white background)

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester lookup request; held until granted
- index  in  N_REQ×4  per-requester palette index; stable while req is high
- grant  out  N_REQ  one-hot, combinational; index[i] is consumed this cycle
- rgb_valid  out  1  red/green/blue/rgb_id/transparent are valid this cycle
- rgb_id  out  ID_W  requester that owns the current result
- red, green, blue  out  4 each  looked-up colour
- transparent  out  1  looked-up index equalled TRANSP_IDX

## Operation
- Fixed: one clock; reset is synchronous and active-high.
- Round-robin pointer rr_ptr (ID_W bits) names the highest-priority requester. Search runs rr_ptr, rr_ptr+1, … mod N_REQ. First requester with req high is granted.
- On a grant to requester g: rr_ptr ← (g+1) mod N_REQ. No grant → rr_ptr unchanged.
- grant is all-zero when req is all-zero. At most one grant bit is set. A grant is never issued during Reset.
- Stage 1 (registered on grant): s1_valid, s1_id = g, s1_idx = index[g].
- Stage 2 (registered): rgb_valid ← s1_valid; rgb_id ← s1_id; {red,green,blue} ← palette[s1_idx]; transparent ← (s1_idx == TRANSP_IDX).
- No output backpressure: the compositor must accept every rgb_valid cycle.
- A requester whose req is high is granted within N_REQ cycles (starvation bound).
- Requester may drop req before grant (abandon); no side effects.
- When rgb_valid is low, red/green/blue/rgb_id/transparent hold their last values.

## Timing
- Reset values: rr_ptr = 0, s1_valid = 0, rgb_valid = 0, rgb_id = 0, red = green = blue = 0, transparent = 0. Stage-1 data registers also clear.
- Reset mid-operation: in-flight stage-1/stage-2 results are discarded; rgb_valid is 0 in the cycle after Reset is sampled high.
- Latency: grant in cycle T → rgb_valid with that requester's colour in cycle T+2.
- Throughput: one lookup per cycle; back-to-back grants give back-to-back rgb_valid.
- Wrap-around: rr_ptr = N_REQ−1, granted → rr_ptr = 0.
- All requesters high continuously → grants cycle 0,1,…,N_REQ−1,0,… one per cycle.

## Structure
- Package sprite_pkg: typedef rgb12_t (packed 4/4/4), typedef pal_idx_t (4 bits), localparam SPRITE_PALETTE [0:15] of rgb12_t, entries in order: FFF, 811, F91, CCB, 521, 353, E41, FD0, 998, EDD, 953, E97, 675, 232, D73, 111.
- Sub-module rr_picker (parameter N): inputs req, ptr; outputs one-hot grant and encoded grant_id; purely combinational.
- Top holds rr_ptr, the two pipeline stages and the package-constant lookup.

## Test plan
- Reset: Reset high 2 cycles with all req high → grant = 0, rgb_valid = 0, all outputs 0; first grant after release goes to requester 0.
- Single requester: req[2]=1, index[2]=4'h7 at T → grant = 4'b0100 at T; at T+2 rgb_valid=1, rgb_id=2, RGB = F,D,0, transparent=0.
- Fairness/wrap: all four req high, indices 1,2,3,4 → grants 0,1,2,3,0 on consecutive cycles; outputs 811, F91, CCB, 521, 811 from T+2.
- Transparency: index 4'h0 → RGB F,F,F, transparent=1; index 4'hF → 1,1,1, transparent=0.
- Pointer skip: rr_ptr=1 (after granting 0), only req[0] and req[3] high → grant 3 then 0.
- Reset mid-flight: grant at T, Reset high at T+1 → rgb_valid stays 0 at T+2; rr_ptr back to 0.
